// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral that fills a small register file. sclk, cs_n and copi are oversampled in the clk domain.
// Define SPI_READBACK_EN to return register contents on cipo during read frames.
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       copi,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, copi_sync;
  logic [CNT_W-1:0]       count, count_nxt;
  logic [FRAME_W-1:0]     shift_reg, shift_nxt;
  logic [DATA_W-1:0]      regs [NUM_REGS];
  logic                   sclk_rise, sclk_fall, cs_hi, copi_s;
  logic                   frame_wr;
  logic [ADDR_W-1:0]      frame_addr;
  logic [DATA_W-1:0]      frame_data;
  logic [IDX_W-1:0]       frame_idx;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // Index SYNC_STAGES-1 is the oldest stage; edges compare the two oldest stages.
  assign sclk_rise  = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
  assign sclk_fall  = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
  assign cs_hi      = cs_sync[SYNC_STAGES-1];
  assign copi_s     = copi_sync[SYNC_STAGES-1];

  assign frame_wr   = shift_reg[FRAME_W-1];
  assign frame_addr = shift_reg[DATA_W +: ADDR_W];
  assign frame_data = shift_reg[DATA_W-1:0];
  assign frame_idx  = frame_addr[IDX_W-1:0];

  always_comb begin
    count_nxt = count;
    shift_nxt = shift_reg;
    if (sclk_rise && count != CNT_FULL) begin
      count_nxt = count + 1'b1;
      shift_nxt = {shift_reg[FRAME_W-2:0], copi_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      copi_sync <= '0;
      state     <= IDLE;
      count     <= '0;
      shift_reg <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      wr_strobe <= '0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_hi) begin
            state     <= SHIFT;
            count     <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          // A bit arriving with the cs_n rise is counted before the frame length is judged.
          count     <= count_nxt;
          shift_reg <= shift_nxt;
          if (cs_hi) begin
            if (count_nxt == CNT_FULL) begin
              state <= COMMIT;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        COMMIT: begin
          if (frame_wr && addr_ok(frame_addr)) begin
            regs[frame_idx]      <= frame_data;
            wr_strobe[frame_idx] <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_reg;
  logic              tx_active, cipo_q;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_addr = shift_nxt[ADDR_W-1:0];

  // Load on the rise that completes the address, then present one bit per sclk fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg    <= '0;
      tx_active <= 1'b0;
      cipo_q    <= 1'b0;
    end else if (state != SHIFT || cs_hi) begin
      tx_active <= 1'b0;
      cipo_q    <= 1'b0;
    end else if (sclk_rise && count == CNT_ADDR && !shift_nxt[ADDR_W]) begin
      tx_active <= 1'b1;
      tx_reg    <= addr_ok(rd_addr) ? regs[rd_addr[IDX_W-1:0]] : '0;
    end else if (sclk_fall && tx_active) begin
      if (count != CNT_FULL) begin
        cipo_q <= tx_reg[DATA_W-1];
        tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
      end else begin
        cipo_q <= 1'b0;
      end
    end
  end

  assign cipo = cipo_q & ~cs_hi;
`else
  assign cipo = 1'b0;
`endif

endmodule
